branch_cond_unit: RTL and testbench

- Registered, parametrised successor to the CPU's combinational branch comparator.
- Evaluates the branch condition of an issued conditional-jump instruction and returns a registered `jump` decision one cycle later, with a valid flag.
- Adds signed/unsigned relational compares, configurable data width, and a bank of hardware loop counters with decrement-and-branch-if-nonzero (DJNZ).
- Sits between the decode stage and the PC-update logic.

---
 rtl/branch_cond_if.sv | 34 +++
 rtl/branch_cond_unit.sv | 147 ++++++++++++++
 tb/tb_branch_cond_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_cond_if.sv
// Request/response bundle between the decode stage and the branch condition unit.
// The decode side is the master: it issues condition requests and loop-counter loads,
// and receives the registered jump decision plus the per-counter zero flags.
interface branch_cond_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_LOOP = 4,
  parameter int SEL_W    = 2
);
  logic                valid_in;
  logic [4:0]          cond;
  logic [WIDTH-1:0]    rddata;
  logic [WIDTH-1:0]    rsdata;
  logic [WIDTH-1:0]    N;
  logic [SEL_W-1:0]    loop_sel;
  logic                loop_load;
  logic [SEL_W-1:0]    load_sel;
  logic [WIDTH-1:0]    loop_load_val;
  logic                flush;
  logic                valid_out;
  logic                jump;
  logic [NUM_LOOP-1:0] loop_zero;

  modport master (
    output valid_in, cond, rddata, rsdata, N, loop_sel,
           loop_load, load_sel, loop_load_val, flush,
    input  valid_out, jump, loop_zero
  );

  modport slave (
    input  valid_in, cond, rddata, rsdata, N, loop_sel,
           loop_load, load_sel, loop_load_val, flush,
    output valid_out, jump, loop_zero
  );
endinterface

// File: rtl/branch_cond_unit.sv
// Branch condition unit: evaluates the condition of an issued conditional jump and
// returns a registered decision one cycle later. Supports equality, signed/unsigned
// relational compares against a register or immediate, single-operand tests, and a
// bank of hardware loop counters with decrement-and-branch-if-nonzero.
module branch_cond_unit #(
  parameter int WIDTH    = 16,
  parameter int NUM_LOOP = 4,
  parameter int SEL_W    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  branch_cond_if.slave bus
);

  // Condition code low bits
  localparam logic [2:0] C_EQ   = 3'b000;
  localparam logic [2:0] C_NE   = 3'b001;
  localparam logic [2:0] C_GT   = 3'b010;
  localparam logic [2:0] C_LT   = 3'b011;
  localparam logic [2:0] C_ZERO = 3'b100;
  localparam logic [2:0] C_NEG  = 3'b101;
  localparam logic [2:0] C_ONES = 3'b110;
  localparam logic [2:0] C_DJNZ = 3'b111;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  // Result registers
  logic valid_q, valid_d;
  logic jump_q,  jump_d;

  // Loop counter bank, exposed as an array for the DJNZ read port
  logic [WIDTH-1:0]    cnt_arr [NUM_LOOP];
  logic [NUM_LOOP-1:0] zero_vec;

  // Request decode
  logic             accept;
  logic             is_djnz;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sel_cnt;
  logic [WIDTH-1:0] sel_dec;
  logic             sel_nonzero;
  logic             load_collide;
  logic             djnz_fire;
  logic             decision;

  // Comparator terms
  logic eq_res;
  logic ugt_res;
  logic ult_res;
  logic sgt_res;
  logic slt_res;

  // A request is only taken when it is not being killed by a flush.
  assign accept  = bus.valid_in & ~bus.flush;
  assign is_djnz = (bus.cond[2:0] == C_DJNZ);

  // cond[3] picks the immediate as second operand; only meaningful for EQ..LT.
  assign opb = bus.cond[3] ? bus.N : bus.rsdata;

  assign eq_res  = (bus.rddata == opb);
  assign ugt_res = (bus.rddata > opb);
  assign ult_res = (bus.rddata < opb);
  assign sgt_res = ($signed(bus.rddata) > $signed(opb));
  assign slt_res = ($signed(bus.rddata) < $signed(opb));

  // DJNZ operates on the pre-edge value of the selected counter.
  assign sel_cnt     = cnt_arr[bus.loop_sel];
  assign sel_dec     = sel_cnt - ONE_W;
  assign sel_nonzero = (sel_cnt != '0);

  // A load to the same counter overrides the decrement and forces a not-taken result.
  assign load_collide = bus.loop_load && (bus.load_sel == bus.loop_sel);

  // Counter actually decrements only for an accepted, non-colliding DJNZ on a nonzero counter.
  assign djnz_fire = accept && is_djnz && !load_collide && sel_nonzero;

  // Branch decision for the current request
  always_comb begin
    decision = 1'b0;
    unique case (bus.cond[2:0])
      C_EQ:   decision = eq_res;
      C_NE:   decision = ~eq_res;
      C_GT:   decision = bus.cond[4] ? sgt_res : ugt_res;
      C_LT:   decision = bus.cond[4] ? slt_res : ult_res;
      C_ZERO: decision = (bus.rddata == '0);
      C_NEG:  decision = bus.rddata[WIDTH-1];
      C_ONES: decision = (bus.rddata == '1);
      C_DJNZ: decision = !load_collide && sel_nonzero && (sel_dec != '0);
      default: decision = 1'b0;
    endcase
  end

  // Next-state for the result registers: jump holds when nothing is accepted.
  always_comb begin
    valid_d = accept;
    jump_d  = accept ? decision : jump_q;
  end

  // Result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      jump_q  <= jump_d;
    end
  end

  // One counter per loop slot; loads are independent of flush.
  for (genvar gi = 0; gi < NUM_LOOP; gi++) begin : g_cnt
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             load_hit;
    logic             dec_hit;

    assign load_hit = bus.loop_load && (bus.load_sel == SEL_W'(gi));
    assign dec_hit  = djnz_fire && (bus.loop_sel == SEL_W'(gi));

    // Load has priority over decrement; otherwise the counter holds.
    always_comb begin
      cnt_d = cnt_q;
      if (load_hit) begin
        cnt_d = bus.loop_load_val;
      end else if (dec_hit) begin
        cnt_d = sel_dec;
      end
    end

    // Counter state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_arr[gi]  = cnt_q;
    assign zero_vec[gi] = (cnt_q == '0);
  end

  assign bus.valid_out = valid_q;
  assign bus.jump      = jump_q;
  assign bus.loop_zero = zero_vec;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Testbench for branch_cond_unit: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a behavioural model of the condition rules.
module tb_branch_cond_unit;
  localparam int W  = 16;
  localparam int NL = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_cond_if #(.WIDTH(W), .NUM_LOOP(NL), .SEL_W(SW)) bif ();

  branch_cond_unit #(.WIDTH(W), .NUM_LOOP(NL), .SEL_W(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int mcnt [NL];
  bit mvalid;
  bit mjump;

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic logic [31:0] exp_zero();
    logic [31:0] z = '0;
    for (int i = 0; i < NL; i++) z[i] = (mcnt[i] == 0);
    return z;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) mcnt[i] = 0;
    mvalid = 0;
    mjump  = 0;
  endtask

  // Apply the rules to the inputs present before the coming edge.
  task automatic predict();
    int a, b, ls;
    bit d, coll;
    int newcnt [NL];
    a    = int'(bif.rddata);
    b    = bif.cond[3] ? int'(bif.N) : int'(bif.rsdata);
    ls   = int'(bif.loop_sel);
    coll = bif.loop_load && (bif.load_sel == bif.loop_sel);
    d    = 0;
    for (int i = 0; i < NL; i++) newcnt[i] = mcnt[i];
    if (bif.valid_in && !bif.flush) begin
      case (bif.cond[2:0])
        3'd0: d = (a == b);
        3'd1: d = (a != b);
        3'd2: d = bif.cond[4] ? (sgn(a) > sgn(b)) : (a > b);
        3'd3: d = bif.cond[4] ? (sgn(a) < sgn(b)) : (a < b);
        3'd4: d = (a == 0);
        3'd5: d = (a >= 32768);
        3'd6: d = (a == 65535);
        default: begin
          if (coll || mcnt[ls] == 0) d = 0;
          else begin
            newcnt[ls] = mcnt[ls] - 1;
            d = (newcnt[ls] != 0);
          end
        end
      endcase
      mvalid = 1;
      mjump  = d;
    end else begin
      mvalid = 0;
    end
    if (bif.loop_load) newcnt[int'(bif.load_sel)] = int'(bif.loop_load_val);
    for (int i = 0; i < NL; i++) mcnt[i] = newcnt[i];
  endtask

  // One clock: predict, step past the edge, compare. exp_jump < 0 means no extra plan check.
  task automatic cycle(input string tag, input int exp_jump);
    predict();
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(bif.valid_out), 32'(mvalid));
    chk({tag, ".jump"},  32'(bif.jump),      32'(mjump));
    chk({tag, ".zero"},  32'(bif.loop_zero), exp_zero());
    if (exp_jump >= 0) chk({tag, ".plan"}, 32'(bif.jump), 32'(exp_jump));
  endtask

  task automatic idle();
    bif.valid_in  = 0;
    bif.flush     = 0;
    bif.loop_load = 0;
  endtask

  task automatic req(input logic [4:0] c, input logic [15:0] rd, input logic [15:0] rs,
                     input logic [15:0] n, input int ls, input bit fl);
    bif.valid_in = 1;
    bif.cond     = c;
    bif.rddata   = rd;
    bif.rsdata   = rs;
    bif.N        = n;
    bif.loop_sel = SW'(ls);
    bif.flush    = fl;
  endtask

  task automatic load(input int sel, input logic [15:0] val);
    bif.loop_load     = 1;
    bif.load_sel      = SW'(sel);
    bif.loop_load_val = val;
  endtask

  initial begin
    bif.cond = '0; bif.rddata = '0; bif.rsdata = '0; bif.N = '0;
    bif.loop_sel = '0; bif.load_sel = '0; bif.loop_load_val = '0;
    idle();
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(bif.valid_out), 32'd0);
    chk("reset.jump",  32'(bif.jump),      32'd0);
    chk("reset.zero",  32'(bif.loop_zero), 32'hF);
    @(negedge clk);
    rst_n = 1;

    // Set some state, then assert reset in the middle of a request
    load(3, 16'd7);
    req(5'b00000, 16'h0042, 16'h0042, 16'h0, 0, 0);
    cycle("pre_rst", 1);
    idle();
    req(5'b00000, 16'h0042, 16'h0042, 16'h0, 0, 0);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    chk("async_rst.valid", 32'(bif.valid_out), 32'd0);
    chk("async_rst.jump",  32'(bif.jump),      32'd0);
    chk("async_rst.zero",  32'(bif.loop_zero), 32'hF);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    // EQ after reset
    req(5'b00000, 16'h1234, 16'h1234, 16'h0, 0, 0);
    cycle("eq", 1);

    // Signed vs unsigned
    req(5'b00010, 16'hFFFF, 16'h0001, 16'h0, 0, 0);
    cycle("ugt", 1);
    req(5'b10010, 16'hFFFF, 16'h0001, 16'h0, 0, 0);
    cycle("sgt", 0);
    req(5'b10011, 16'hFFFF, 16'h0001, 16'h0, 0, 0);
    cycle("slt", 1);

    // Immediate operand select
    req(5'b01000, 16'h0005, 16'h0000, 16'h0005, 0, 0);
    cycle("imm_eq", 1);
    req(5'b01000, 16'h0005, 16'h0000, 16'h0006, 0, 0);
    cycle("imm_ne", 0);

    // DJNZ countdown on counter 2
    idle();
    load(2, 16'd3);
    cycle("djnz_load", -1);
    idle();
    req(5'b00111, 16'h0, 16'h0, 16'h0, 2, 0);
    cycle("djnz1", 1);
    cycle("djnz2", 1);
    cycle("djnz3", 0);
    cycle("djnz4", 0);
    chk("djnz4.zero2", 32'(bif.loop_zero[2]), 32'd1);

    // Load/DJNZ collision on the same counter
    idle();
    load(1, 16'd5);
    cycle("coll_load", -1);
    req(5'b00111, 16'h0, 16'h0, 16'h0, 1, 0);
    load(1, 16'd9);
    cycle("coll_same", 0);
    idle();
    load(1, 16'd5);
    cycle("coll_reload", -1);
    req(5'b00111, 16'h0, 16'h0, 16'h0, 1, 0);
    load(0, 16'd8);
    cycle("coll_diff", 1);

    // Flush kills the request but not the counter state
    idle();
    load(0, 16'd2);
    cycle("flush_load", -1);
    idle();
    req(5'b00111, 16'h0, 16'h0, 16'h0, 0, 1);
    cycle("flush", 1);
    chk("flush.valid_low", 32'(bif.valid_out), 32'd0);
    idle();
    req(5'b00111, 16'h0, 16'h0, 16'h0, 0, 0);
    cycle("after_flush", 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] rd;
      idle();
      case ($urandom_range(0, 4))
        0: rd = 16'h0000;
        1: rd = 16'hFFFF;
        2: rd = 16'h8000;
        3: rd = 16'h7FFF;
        default: rd = 16'($urandom);
      endcase
      bif.valid_in = ($urandom_range(0, 3) != 0);
      bif.flush    = ($urandom_range(0, 7) == 0);
      bif.cond     = 5'($urandom);
      bif.rddata   = rd;
      bif.rsdata   = ($urandom_range(0, 3) == 0) ? rd : 16'($urandom);
      bif.N        = ($urandom_range(0, 3) == 0) ? rd : 16'($urandom);
      bif.loop_sel = SW'($urandom);
      if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, NL - 1)), 16'($urandom_range(0, 4)));
      cycle("rand", -1);
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
